// File: rtl/countdown_bcd_3_digits.sv
// Presettable 3-digit BCD countdown timer with active-low 7-segment outputs.
// Optional AUTO_RELOAD_EN: on expiry, reload the last loaded preset and keep running.

module countdown_seg7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  // {g,f,e,d,c,b,a}, active-low
  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module countdown_bcd_3_digits #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        CLOCK_50,
  input  logic        clr_n,
  input  logic        load,
  input  logic [11:0] preset,
  input  logic        start,
  input  logic        pause,
  output logic [11:0] bcd,
  output logic [6:0]  H0,
  output logic [6:0]  H1,
  output logic [6:0]  H2,
  output logic        running,
  output logic        zero,
  output logic        done
);
  localparam int NUM_DIGITS = 3;
  localparam int PW         = $clog2(TICK_DIV);

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state_q, state_nx;
  digits_t         bcd_q, bcd_nx, preset_d, preset_san, dec_val;
  logic [PW-1:0]   presc_q, presc_nx;
  logic            done_q, done_nx;
  logic            tick;
  logic [NUM_DIGITS-1:0][6:0] seg;

`ifdef AUTO_RELOAD_EN
  digits_t         reload_q, reload_nx;
`endif

  // Ripple-borrow decrement from the units digit upward.
  function automatic digits_t bcd_dec(input digits_t v);
    digits_t r;
    logic    borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (v[i] == 4'd0) begin
          r[i] = 4'd9;
        end else begin
          r[i]   = v[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign preset_d = preset;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign preset_san[g] = (preset_d[g] > 4'd9) ? 4'd9 : preset_d[g];
    countdown_seg7 u_seg (.digit(bcd_q[g]), .seg(seg[g]));
  end

  assign H0      = seg[0];
  assign H1      = seg[1];
  assign H2      = seg[2];
  assign bcd     = bcd_q;
  assign zero    = (bcd_q == '0);
  assign running = (state_q == RUN);
  assign done    = done_q;

  assign tick    = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign dec_val = bcd_dec(bcd_q);

  always_comb begin
    state_nx  = state_q;
    bcd_nx    = bcd_q;
    presc_nx  = presc_q;
    done_nx   = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_nx = reload_q;
`endif
    if (load && state_q != RUN) begin
      bcd_nx   = preset_san;
      presc_nx = '0;
`ifdef AUTO_RELOAD_EN
      reload_nx = preset_san;
`endif
      if (state_q == DONE) state_nx = IDLE;
    end else if (start && (state_q == IDLE || state_q == PAUSE) && !zero) begin
      state_nx = RUN;
      if (state_q == IDLE) presc_nx = '0;
    end else if (state_q == RUN) begin
      presc_nx = tick ? '0 : presc_q + PW'(1);
      // A decrement on the pause edge still lands; expiry overrides the pause.
      if (tick && dec_val == '0) begin
        done_nx  = 1'b1;
        bcd_nx   = '0;
        state_nx = DONE;
`ifdef AUTO_RELOAD_EN
        if (reload_q != '0) begin
          bcd_nx   = reload_q;
          state_nx = pause ? PAUSE : RUN;
        end
`endif
      end else begin
        if (tick)  bcd_nx   = dec_val;
        if (pause) state_nx = PAUSE;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_nx;
      bcd_q    <= bcd_nx;
      presc_q  <= presc_nx;
      done_q   <= done_nx;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_nx;
`endif
    end
  end
endmodule

// File: tb/tb_countdown_bcd_3_digits.sv
// Bench for countdown_bcd_3_digits: integer-level reference model checked every cycle,
// plus directed literal checks. Define AUTO_RELOAD_EN to exercise the reload variant.

module tb_countdown_bcd_3_digits;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        clr_n, load, start, pause;
  logic [11:0] preset;
  logic [11:0] bcd;
  logic [6:0]  H0, H1, H2;
  logic        running, zero, done;

  countdown_bcd_3_digits #(.TICK_DIV(TD)) dut (
    .CLOCK_50(clk), .clr_n(clr_n), .load(load), .preset(preset),
    .start(start), .pause(pause), .bcd(bcd), .H0(H0), .H1(H1), .H2(H2),
    .running(running), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: count as a plain integer, mode as a small int.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  logic [6:0] seg_tab [10];
  bit  m_valid = 0;
  int  m_cnt, m_mode, m_ph, m_reload;
  bit  m_done;

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
  end

  function automatic int clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 9 : int'(n);
  endfunction

  function automatic int sanitize(input logic [11:0] p);
    return clamp9(p[11:8]) * 100 + clamp9(p[7:4]) * 10 + clamp9(p[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // Inputs only change just after a rising edge, so at the falling edge they hold
  // exactly what the next rising edge samples: compare, then advance the model.
  always @(negedge clk) begin
    if (m_valid)
      check("cycle",
            {bcd, H0, H1, H2, running, zero, done},
            {to_bcd(m_cnt), seg_tab[m_cnt % 10], seg_tab[(m_cnt / 10) % 10],
             seg_tab[m_cnt / 100], m_mode == M_RUN, m_cnt == 0, m_done});
    if (!clr_n) begin
      m_valid = 1; m_cnt = 0; m_mode = M_IDLE; m_ph = 0; m_done = 0; m_reload = 0;
    end else if (m_valid) begin
      m_done = 0;
      if (load && m_mode != M_RUN) begin
        m_cnt = sanitize(preset); m_reload = m_cnt; m_ph = 0;
        if (m_mode == M_DONE) m_mode = M_IDLE;
      end else if (start && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_cnt != 0) begin
        if (m_mode == M_IDLE) m_ph = 0;
        m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        m_ph++;
        if (m_ph == TD) begin
          m_ph = 0;
          if (m_cnt == 1) begin
            m_done = 1;
`ifdef AUTO_RELOAD_EN
            if (m_reload != 0) begin
              m_cnt = m_reload;
              if (pause) m_mode = M_PAUSE;
            end else begin
              m_cnt = 0; m_mode = M_DONE;
            end
`else
            m_cnt = 0; m_mode = M_DONE;
`endif
          end else begin
            m_cnt--;
            if (pause) m_mode = M_PAUSE;
          end
        end else if (pause) m_mode = M_PAUSE;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clr_n = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; preset = '0;
    step(2);
    clr_n = 1'b1;
    check("rst_bcd",  36'(bcd), 36'h000);
    check("rst_H",    36'({H2, H1, H0}), 36'({3{7'b1000000}}));
    check("rst_flags", 36'({running, zero, done}), 36'b010);
    start = 1'b1; step(1); start = 1'b0;
    check("start_at_zero", 36'({running, bcd}), 36'h0000);

    // borrow chain 105 -> 099
    load = 1'b1; preset = 12'h105; step(1); load = 1'b0;
    check("load_105", 36'(bcd), 36'h105);
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    check("pre_tick", 36'(bcd), 36'h105);
    step(1);
    check("first_tick", 36'(bcd), 36'h104);
    step(20);
    check("borrow_099", 36'(bcd), 36'h099);
    check("seg_099", 36'({H2, H1, H0}), 36'({7'b1000000, 7'b0010000, 7'b0010000}));

    // synchronous reset mid-count
    clr_n = 1'b0; step(2); clr_n = 1'b1;
    check("midrun_rst_bcd", 36'(bcd), 36'h000);
    check("midrun_rst_flags", 36'({running, zero, done}), 36'b010);
    check("midrun_rst_H", 36'({H2, H1, H0}), 36'({3{7'b1000000}}));

    // pause / resume keeps the prescaler phase
    load = 1'b1; preset = 12'h050; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    pause = 1'b1; step(1); pause = 1'b0;
    check("paused", 36'(running), 36'h0);
    step(10);
    check("pause_hold", 36'(bcd), 36'h050);
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    check("resume_1", 36'(bcd), 36'h050);
    step(1);
    check("resume_2", 36'(bcd), 36'h049);

    // sanitize and load-ignored-in-run
    pause = 1'b1; step(1); pause = 1'b0;
    load = 1'b1; preset = 12'hA3F; step(1); load = 1'b0;
    check("sanitize", 36'(bcd), 36'h939);
    start = 1'b1; step(1); start = 1'b0;
    load = 1'b1; preset = 12'h123;
    step(3);
    check("load_in_run", 36'(bcd), 36'h939);
    step(1);
    check("count_on", 36'(bcd), 36'h938);
    load = 1'b0;

    clr_n = 1'b0; step(1); clr_n = 1'b1;

    // expiry
    load = 1'b1; preset = 12'h002; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(7);
    check("exp_pre", 36'({done, bcd}), 36'h0001);
    step(1);
`ifdef AUTO_RELOAD_EN
    check("reload_val", 36'({running, done, bcd}), 36'h3002);
    step(1);
    check("reload_done_low", 36'({running, done}), 36'h2);
    step(6);
    check("reload_pre2", 36'(bcd), 36'h001);
    step(1);
    check("reload_again", 36'({running, done, bcd}), 36'h3002);
`else
    check("exp_zero", 36'({running, done, bcd}), 36'h1000);
    step(1);
    check("exp_done_low", 36'({running, done, bcd}), 36'h0000);
    start = 1'b1; step(1); start = 1'b0;
    check("start_in_done", 36'({running, done, bcd}), 36'h0000);
`endif
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
